// File: rtl/alu_cmd_ctrl_if.sv
// Signal bundle between the ALU command sequencer and its UART/ALU neighbours.
// The master modport is the sequencer; the slave modport is the surrounding system.
interface alu_cmd_ctrl_if #(
    parameter int OPER_WIDTH = 8,
    parameter int OUT_WIDTH  = 16
);
    logic [7:0]            rx_p_data;
    logic                  rx_d_vld;
    logic [OPER_WIDTH-1:0] alu_a;
    logic [OPER_WIDTH-1:0] alu_b;
    logic [3:0]            alu_fun;
    logic                  alu_en;
    logic [OUT_WIDTH-1:0]  alu_out;
    logic                  alu_out_valid;
    logic [7:0]            tx_p_data;
    logic                  tx_d_vld;
    logic                  tx_busy;
    logic                  ctrl_busy;
    logic                  rx_drop;
    logic                  res_err;

    modport master (
        input  rx_p_data, rx_d_vld, alu_out, alu_out_valid, tx_busy,
        output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld,
               ctrl_busy, rx_drop, res_err
    );

    modport slave (
        output rx_p_data, rx_d_vld, alu_out, alu_out_valid, tx_busy,
        input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld,
               ctrl_busy, rx_drop, res_err
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Builds ALU command frames from UART RX bytes, fires the ALU once per frame
// and returns the 16-bit result to UART TX as two bytes, low byte first.
module alu_cmd_ctrl #(
    parameter int          OPER_WIDTH  = 8,
    parameter int          OUT_WIDTH   = 16,
    parameter logic [7:0]  CMD_OPER    = 8'hCC,
    parameter logic [7:0]  CMD_NOOPER  = 8'hDD,
    parameter int          RES_TIMEOUT = 15
) (
    input logic               i_clk,
    input logic               i_rst,
    alu_cmd_ctrl_if.master    bus
);
    localparam int TMO_W = $clog2(RES_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_GET_FUN,
        S_EXEC,
        S_WAIT_RES,
        S_SEND_LO,
        S_SEND_HI
    } state_e;

    state_e                r_state;
    logic [OPER_WIDTH-1:0] r_a;
    logic [OPER_WIDTH-1:0] r_b;
    logic [OPER_WIDTH-1:0] r_alu_a;
    logic [OPER_WIDTH-1:0] r_alu_b;
    logic [3:0]            r_alu_fun;
    logic                  r_alu_en;
    logic [OUT_WIDTH-1:0]  r_res;
    logic [TMO_W-1:0]      r_tmo;
    logic [7:0]            r_tx_data;
    logic                  r_tx_vld;
    logic                  r_ctrl_busy;
    logic                  r_rx_drop;
    logic                  r_res_err;
    logic                  w_rx_blocked;

    // Bytes arriving while a command is executing or being answered are never queued.
    assign w_rx_blocked = (r_state == S_EXEC) || (r_state == S_WAIT_RES) ||
                          (r_state == S_SEND_LO) || (r_state == S_SEND_HI);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= '0;
            r_alu_en    <= 1'b0;
            r_res       <= '0;
            r_tmo       <= '0;
            r_tx_data   <= '0;
            r_tx_vld    <= 1'b0;
            r_ctrl_busy <= 1'b0;
            r_rx_drop   <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            r_alu_en  <= 1'b0;
            r_res_err <= 1'b0;
            r_rx_drop <= bus.rx_d_vld && w_rx_blocked;

            case (r_state)
                S_IDLE: begin
                    if (bus.rx_d_vld) begin
                        if (bus.rx_p_data == CMD_OPER) begin
                            r_state     <= S_GET_A;
                            r_ctrl_busy <= 1'b1;
                        end else if (bus.rx_p_data == CMD_NOOPER) begin
                            r_state     <= S_GET_FUN;
                            r_ctrl_busy <= 1'b1;
                        end else begin
                            r_rx_drop <= 1'b1;
                        end
                    end
                end

                S_GET_A: begin
                    if (bus.rx_d_vld) begin
                        r_a     <= bus.rx_p_data[OPER_WIDTH-1:0];
                        r_state <= S_GET_B;
                    end
                end

                S_GET_B: begin
                    if (bus.rx_d_vld) begin
                        r_b     <= bus.rx_p_data[OPER_WIDTH-1:0];
                        r_state <= S_GET_FUN;
                    end
                end

                S_GET_FUN: begin
                    // ALU operands only change here, so they hold through EXEC and beyond.
                    if (bus.rx_d_vld) begin
                        r_alu_a   <= r_a;
                        r_alu_b   <= r_b;
                        r_alu_fun <= bus.rx_p_data[3:0];
                        r_alu_en  <= 1'b1;
                        r_state   <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT_RES;
                end

                S_WAIT_RES: begin
                    if (bus.alu_out_valid) begin
                        r_res     <= bus.alu_out;
                        r_tmo     <= '0;
                        r_tx_data <= bus.alu_out[7:0];
                        r_tx_vld  <= ~bus.tx_busy;
                        r_state   <= S_SEND_LO;
                    end else if (r_tmo == TMO_W'(RES_TIMEOUT - 1)) begin
                        r_res     <= '1;
                        r_tmo     <= '0;
                        r_res_err <= 1'b1;
                        r_tx_data <= 8'hFF;
                        r_tx_vld  <= ~bus.tx_busy;
                        r_state   <= S_SEND_LO;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end

                S_SEND_LO: begin
                    // Accept is the first cycle BUSY is seen while the byte is offered.
                    if (r_tx_vld) begin
                        if (bus.tx_busy) begin
                            r_tx_vld  <= 1'b0;
                            r_tx_data <= r_res[OUT_WIDTH-1:OPER_WIDTH];
                            r_state   <= S_SEND_HI;
                        end
                    end else if (!bus.tx_busy) begin
                        r_tx_vld <= 1'b1;
                    end
                end

                S_SEND_HI: begin
                    if (r_tx_vld) begin
                        if (bus.tx_busy) begin
                            r_tx_vld    <= 1'b0;
                            r_ctrl_busy <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (!bus.tx_busy) begin
                        r_tx_vld <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_ctrl_busy <= 1'b0;
                    r_tx_vld    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_fun   = r_alu_fun;
    assign bus.alu_en    = r_alu_en;
    assign bus.tx_p_data = r_tx_data;
    assign bus.tx_d_vld  = r_tx_vld;
    assign bus.ctrl_busy = r_ctrl_busy;
    assign bus.rx_drop   = r_rx_drop;
    assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered-ALU model and a simple
// UART TX model that goes busy for three cycles per accepted byte.
module tb_alu_cmd_ctrl;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_ctrl_if #(.OPER_WIDTH(8), .OUT_WIDTH(16)) bus ();

    alu_cmd_ctrl dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic       alu_mute   = 1'b0;
    logic       force_busy = 1'b0;
    int         tx_cnt;
    logic [7:0] txq[$];
    int         en_cnt, drop_cnt, err_cnt, viol_cnt;
    logic       prev_vld;
    logic [7:0] prev_data;

    // Registered ALU: result and valid one cycle after EN.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_out       <= '0;
            bus.alu_out_valid <= 1'b0;
        end else begin
            bus.alu_out_valid <= 1'b0;
            if (bus.alu_en && !alu_mute) begin
                bus.alu_out_valid <= 1'b1;
                case (bus.alu_fun)
                    OP_ADD:  bus.alu_out <= {8'h00, bus.alu_a} + {8'h00, bus.alu_b};
                    OP_SUB:  bus.alu_out <= {8'h00, bus.alu_a} - {8'h00, bus.alu_b};
                    OP_MUL:  bus.alu_out <= {8'h00, bus.alu_a} * {8'h00, bus.alu_b};
                    default: bus.alu_out <= 16'h0000;
                endcase
            end
        end
    end

    // UART TX: captures an offered byte while idle, then stays busy three cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tx_busy <= 1'b0;
            tx_cnt      <= 0;
        end else if (force_busy) begin
            bus.tx_busy <= 1'b1;
            tx_cnt      <= 0;
        end else if (bus.tx_busy) begin
            if (tx_cnt == 0) bus.tx_busy <= 1'b0;
            else             tx_cnt <= tx_cnt - 1;
        end else if (bus.tx_d_vld) begin
            txq.push_back(bus.tx_p_data);
            bus.tx_busy <= 1'b1;
            tx_cnt      <= 2;
        end
    end

    always @(negedge clk) begin
        if (bus.alu_en)  en_cnt++;
        if (bus.rx_drop) drop_cnt++;
        if (bus.res_err) err_cnt++;
        if (bus.tx_d_vld && !prev_vld && bus.tx_busy) viol_cnt++;
        if (bus.tx_d_vld && prev_vld && (bus.tx_p_data !== prev_data)) viol_cnt++;
        prev_vld  = bus.tx_d_vld;
        prev_data = bus.tx_p_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic clear_mon();
        en_cnt = 0; drop_cnt = 0; err_cnt = 0; viol_cnt = 0;
        txq.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_p_data = b;
        bus.rx_d_vld  = 1'b1;
        @(negedge clk);
        bus.rx_d_vld  = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [15:0] exp);
        int k = 0;
        logic [15:0] got;
        while ((txq.size() < 2 || bus.ctrl_busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        got = (txq.size() == 2) ? {txq[1], txq[0]} : 16'hxxxx;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: response hi/lo %h (%0d bytes) required %h", name, got, txq.size(), exp);
        end
    endtask

    task automatic test_reset();
        bus.rx_p_data = 8'h00;
        bus.rx_d_vld  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.alu_en !== 1'b0)     begin errors++; $display("FAIL reset_alu_en: got %b need 0", bus.alu_en); end
        checks++; if (bus.tx_d_vld !== 1'b0)   begin errors++; $display("FAIL reset_tx_vld: got %b need 0", bus.tx_d_vld); end
        checks++; if (bus.ctrl_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b need 0", bus.ctrl_busy); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.tx_p_data} !== 28'h0)
            begin errors++; $display("FAIL reset_data: got %h need 0", {bus.alu_a, bus.alu_b, bus.alu_fun, bus.tx_p_data}); end
        checks++; if ({bus.rx_drop, bus.res_err} !== 2'b00)
            begin errors++; $display("FAIL reset_pulses: got %b need 00", {bus.rx_drop, bus.res_err}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_add();
        clear_mon();
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h05); send_byte({4'hA, OP_ADD});
        // Now in EXEC; upper nibble of the function byte must be ignored.
        checks++; if (bus.alu_en !== 1'b1) begin errors++; $display("FAIL add_en: got %b need 1", bus.alu_en); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {8'h0A, 8'h05, OP_ADD})
            begin errors++; $display("FAIL add_operands: got %h need %h", {bus.alu_a, bus.alu_b, bus.alu_fun}, {8'h0A, 8'h05, OP_ADD}); end
        @(negedge clk);
        checks++; if (bus.tx_d_vld !== 1'b0) begin errors++; $display("FAIL add_early_tx: got %b need 0", bus.tx_d_vld); end
        @(negedge clk);
        checks++; if ({bus.tx_d_vld, bus.tx_p_data} !== {1'b1, 8'h0F})
            begin errors++; $display("FAIL add_latency: got vld %b data %h need vld 1 data 0f", bus.tx_d_vld, bus.tx_p_data); end
        wait_resp("add_resp", 16'h000F);
        checks++; if ({en_cnt, drop_cnt, err_cnt} !== {32'd1, 32'd0, 32'd0})
            begin errors++; $display("FAIL add_pulses: en %0d drop %0d err %0d need 1 0 0", en_cnt, drop_cnt, err_cnt); end
    endtask

    task automatic test_mul_reuse();
        clear_mon();
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte({4'h0, OP_MUL});
        wait_resp("mul_resp", 16'hFE01);
        txq.delete();
        send_byte(8'hDD); send_byte({4'h0, OP_SUB});
        wait_resp("reuse_resp", 16'h0000);
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {8'hFF, 8'hFF, OP_SUB})
            begin errors++; $display("FAIL reuse_operands: got %h need %h", {bus.alu_a, bus.alu_b, bus.alu_fun}, {8'hFF, 8'hFF, OP_SUB}); end
        checks++; if (en_cnt !== 2) begin errors++; $display("FAIL reuse_en_count: got %0d need 2", en_cnt); end
    endtask

    task automatic test_drop();
        int k = 0;
        clear_mon();
        send_byte(8'h3C);
        @(negedge clk);
        checks++; if ({drop_cnt, bus.ctrl_busy} !== {32'd1, 1'b0})
            begin errors++; $display("FAIL drop_idle: drops %0d busy %b need 1 0", drop_cnt, bus.ctrl_busy); end
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h05); send_byte({4'h0, OP_ADD});
        while (!bus.tx_d_vld && k < 50) begin @(negedge clk); k++; end
        checks++; if (bus.tx_d_vld !== 1'b1) begin errors++; $display("FAIL drop_send_lo: tx_vld %b need 1", bus.tx_d_vld); end
        bus.rx_p_data = 8'h11;
        bus.rx_d_vld  = 1'b1;
        @(negedge clk);
        bus.rx_d_vld  = 1'b0;
        wait_resp("drop_resp", 16'h000F);
        checks++; if ({drop_cnt, en_cnt} !== {32'd2, 32'd1})
            begin errors++; $display("FAIL drop_count: drops %0d en %0d need 2 1", drop_cnt, en_cnt); end
    endtask

    task automatic test_tx_busy();
        int seen = 0;
        clear_mon();
        force_busy = 1'b1;
        send_byte(8'hCC); send_byte(8'h30); send_byte(8'h47); send_byte({4'h0, OP_ADD});
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_d_vld) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL busy_hold: tx_vld seen %0d cycles need 0", seen); end
        force_busy = 1'b0;
        wait_resp("busy_resp", 16'h0077);
        checks++; if (viol_cnt !== 0) begin errors++; $display("FAIL busy_protocol: violations %0d need 0", viol_cnt); end
    endtask

    task automatic test_timeout();
        int k = 0;
        clear_mon();
        alu_mute = 1'b1;
        send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte({4'h0, OP_SUB});
        checks++; if (bus.alu_en !== 1'b1) begin errors++; $display("FAIL tmo_en: got %b need 1", bus.alu_en); end
        // EXEC cycle, then 15 WAIT_RES cycles; the pulse shows in the cycle after.
        while (!bus.res_err && k < 40) begin @(negedge clk); k++; end
        checks++; if (k !== 16) begin errors++; $display("FAIL tmo_delay: res_err after %0d cycles need 16", k); end
        wait_resp("tmo_resp", 16'hFFFF);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL tmo_err_count: got %0d need 1", err_cnt); end
        alu_mute = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        send_byte(8'hCC); send_byte(8'h0A);
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_p_data, bus.tx_d_vld,
                       bus.ctrl_busy, bus.rx_drop, bus.res_err} !== 33'h0)
            begin errors++; $display("FAIL midrst_outputs: a %h b %h fun %h busy %b need all 0",
                                     bus.alu_a, bus.alu_b, bus.alu_fun, bus.ctrl_busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h05); send_byte({4'h0, OP_ADD});
        wait_resp("midrst_resp", 16'h000F);
        repeat (10) @(negedge clk);
        checks++; if ({txq.size(), en_cnt} !== {32'd2, 32'd1})
            begin errors++; $display("FAIL midrst_spurious: bytes %0d en %0d need 2 1", txq.size(), en_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_mul_reuse();
        test_drop();
        test_tx_busy();
        test_timeout();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
